hilo_unit: RTL and testbench
============================

# hilo_unit

Controller and architectural state for the MIPS HI/LO register pair. It sits directly downstream of the iterative multiplier and issues MULT and MULTU requests to it. It holds the validIn level handshake, captures Hi/Lo when the multiplier reports completion, and serves MFHI, MFLO, MTHI and MTLO. It stalls the pipeline while a multiply is outstanding and uses a watchdog to detect a multiplier that never completes.

## Interface
Parameters:
- MAX_BUSY, 64: maximum cycles in BUSY before the watchdog fires.

Ports:
- clk  in  1  clock; everything is updated on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  operation presented this cycle.
- op  in  3  operation code, hilo_pkg::hilo_op_t.
- rs_data  in  32  operand A, or the source value for MTHI/MTLO.
- rt_data  in  32  operand B.
- stall  out  1  combinational; the op is not accepted this cycle.
- rd_data  out  32  MFHI/MFLO result, registered.
- rd_valid  out  1  one-cycle pulse qualifying rd_data.
- err  out  1  sticky watchdog flag, cleared only by reset.
- mult_validIn  out  1  level request to the multiplier.
- mult_sign  out  1  1 for MULT, 0 for MULTU.
- mult_SrcA, mult_SrcB  out  32  latched operands.
- mult_validOut  in  1  multiplier completion.
- mult_Hi, mult_Lo  in  32  multiplier product halves.

## Operation
- An op is accepted when op_valid && !stall.
- FSM states:
  - IDLE: no multiply outstanding.
  - BUSY: mult_validIn=1. Operands and sign are held constant.
  - DRAIN: exactly one cycle with mult_validIn=0, so the multiplier clears its internal state.
- MULT/MULTU accepted in IDLE:
  - Latch rs_data/rt_data into mult_SrcA/mult_SrcB and set mult_sign.
  - Go to BUSY.
  - Clear the watchdog count.
- In BUSY with mult_validOut=1:
  - Hi<=mult_Hi, Lo<=mult_Lo.
  - Go to DRAIN.
- In BUSY with no validOut and the watchdog count reaching MAX_BUSY-1:
  - err<=1.
  - Go to DRAIN.
  - Hi/Lo stay unchanged.
- DRAIN always goes to IDLE. mult_validOut is ignored in DRAIN and IDLE.
- MFHI/MFLO: rd_data<=Hi or Lo, and rd_valid=1 on the next cycle.
- MTHI/MTLO: Hi or Lo <= rs_data on the accept edge.
- stall is op_valid && (state==BUSY || (state==DRAIN && op is MULT/MULTU)). All HI/LO reads and writes are therefore ordered after the pending product.
- NOP and unused encodings are accepted with no effect.
- Reset state:
  - state=IDLE.
  - Hi=Lo=0, rd_data=0, rd_valid=0, err=0.
  - mult_validIn=0, mult_sign=0, mult_SrcA=mult_SrcB=0.
  - Reset in BUSY abandons the multiply. Because validIn drops, the multiplier self-clears.

## Timing
- MULT accepted at edge t: mult_validIn is high from cycle t+1.
- Completion: validOut first seen high in cycle k means Hi/Lo are updated at edge k and are readable by an MFHI accepted in cycle k+1 (DRAIN).
- The next MULT can be accepted at cycle k+2 at the earliest (IDLE).
- MFHI/MFLO latency is 1 cycle.
- An MTHI accepted in the same cycle as an MFHI is impossible: there is a single op port.
- MTHI followed by MFHI in the next cycle returns the new value.
- mult_validIn is registered and driven from state. It never toggles while in BUSY.

## Structure
- Package hilo_pkg contains:
  - hilo_op_t: NOP=0, MULT=1, MULTU=2, MFHI=3, MFLO=4, MTHI=5, MTLO=6.
  - hilo_state_t: IDLE, BUSY, DRAIN.
- The multiplier is instantiated at the ALU level and wired to the mult_* ports. It is not nested inside this block.
- The block is otherwise flat. The watchdog is a $clog2(MAX_BUSY)-bit counter inside it.

## Test plan
Use a behavioural multiplier model with a configurable latency for the first four scenarios.
- MULTU 3×5, latency 4 → stall high for 4 cycles; then MFHI → rd_data=0, and MFLO → rd_data=15.
- MULT 0xFFFFFFFE×3 → Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; mult_sign=1 throughout BUSY.
- MFLO issued during BUSY → stalled until DRAIN, then returns the new Lo, not the old one. A back-to-back MULT in DRAIN stalls for one cycle, and mult_validIn is low for exactly that cycle.
- MTHI 0xDEADBEEF then MFHI on the next cycle → rd_data=0xDEADBEEF. MTLO during BUSY is stalled, and its value overrides the product Lo.
- Model never asserts validOut → after 64 BUSY cycles err=1, the block returns to IDLE via DRAIN, Hi/Lo are unchanged, and further ops work.
- Assert reset in the middle of BUSY → all outputs take their reset values the next cycle; a subsequent MULTU 7×6 yields Lo=42.

Source files
------------

// File: rtl/hilo_pkg.sv
// -----------------------------------------------------------------------------
// hilo_pkg
//   Shared types for the HI/LO controller: the operation encoding presented on
//   the op port, the controller FSM state, and a couple of small helpers.
// -----------------------------------------------------------------------------
package hilo_pkg;

    localparam int unsigned DATA_W = 32;

    // Operation encoding presented with op_valid. Encoding 7 is unused and is
    // treated as a NOP by the controller.
    typedef enum logic [2:0] {
        NOP   = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        MFHI  = 3'd3,
        MFLO  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } hilo_op_t;

    // Controller state.
    //   IDLE  : no multiply outstanding
    //   BUSY  : request held high towards the multiplier
    //   DRAIN : one cycle with the request low so the multiplier self-clears
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } hilo_state_t;

    // True for the two opcodes that start a multiply.
    function automatic logic op_is_mult(input hilo_op_t o);
        return (o == MULT) || (o == MULTU);
    endfunction

    // True for opcodes that touch the HI/LO pair (read or write).
    function automatic logic op_is_hilo(input hilo_op_t o);
        return (o == MFHI) || (o == MFLO) || (o == MTHI) || (o == MTLO);
    endfunction

endpackage

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//   Controller and architectural state for the MIPS HI/LO register pair.
//   Issues MULT/MULTU to an external iterative multiplier over a level
//   handshake (mult_validIn held high until mult_validOut), captures the
//   product into HI/LO, and serves MFHI/MFLO/MTHI/MTLO. The pipeline is
//   stalled while a multiply is outstanding; a watchdog abandons a multiply
//   that never completes and raises a sticky error.
//
// Parameters
//   MAX_BUSY      maximum cycles spent in BUSY before the watchdog fires
//
// Ports
//   clk           clock, rising edge
//   reset         synchronous active-high reset
//   op_valid      operation presented this cycle
//   op            operation code (hilo_op_t)
//   rs_data       operand A / source for MTHI, MTLO
//   rt_data       operand B
//   stall         combinational: presented op is not accepted this cycle
//   rd_data       registered MFHI/MFLO result
//   rd_valid      one-cycle pulse qualifying rd_data
//   err           sticky watchdog flag (cleared by reset only)
//   mult_validIn  level request to the multiplier
//   mult_sign     1 = signed (MULT), 0 = unsigned (MULTU)
//   mult_SrcA/B   latched multiplier operands
//   mult_validOut multiplier completion
//   mult_Hi/Lo    multiplier product halves
// -----------------------------------------------------------------------------
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int unsigned MAX_BUSY = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  hilo_op_t          op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              err,
    output logic              mult_validIn,
    output logic              mult_sign,
    output logic [DATA_W-1:0] mult_SrcA,
    output logic [DATA_W-1:0] mult_SrcB,
    input  logic              mult_validOut,
    input  logic [DATA_W-1:0] mult_Hi,
    input  logic [DATA_W-1:0] mult_Lo
);

    // Watchdog width; kept at least one bit so tiny MAX_BUSY values still
    // elaborate.
    localparam int unsigned    CNT_W   = (MAX_BUSY > 2) ? $clog2(MAX_BUSY) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_BUSY - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    hilo_state_t       state_q, state_d;
    logic [CNT_W-1:0]  wd_q, wd_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic              vin_q, vin_d;
    logic              sign_q, sign_d;
    logic [DATA_W-1:0] srca_q, srca_d;
    logic [DATA_W-1:0] srcb_q, srcb_d;

    // -------------------------------------------------------------------------
    // Accept / stall decode
    // -------------------------------------------------------------------------
    logic is_mul;
    logic accept;
    logic mul_start;
    logic mul_done;
    logic wd_fire;

    assign is_mul = op_is_mult(op);

    // Everything stalls in BUSY so HI/LO accesses order after the product.
    // In DRAIN only a new multiply must wait: the request has to stay low for
    // one full cycle before it can rise again.
    assign stall  = op_valid && ((state_q == BUSY) ||
                                 ((state_q == DRAIN) && is_mul));
    assign accept = op_valid && !stall;

    assign mul_start = accept && is_mul && (state_q == IDLE);
    assign mul_done  = (state_q == BUSY) && mult_validOut;
    assign wd_fire   = (state_q == BUSY) && !mult_validOut && (wd_q == WD_LAST);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (mul_start)            state_d = BUSY;
            BUSY:    if (mul_done || wd_fire)  state_d = DRAIN;
            DRAIN:                             state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM outputs and datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        // Hold by default; rd_valid is a pulse.
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = err_q;
        sign_d     = sign_q;
        srca_d     = srca_q;
        srcb_d     = srcb_q;
        wd_d       = wd_q;

        // Request is a registered copy of "next state is BUSY", so it rises
        // the cycle after accept and cannot glitch within BUSY.
        vin_d = (state_d == BUSY);

        // Watchdog counts BUSY cycles for the current multiply.
        if (mul_start) begin
            wd_d = '0;
        end else if (state_q == BUSY) begin
            wd_d = wd_q + 1'b1;
        end

        // Operands and sign are captured once and held through BUSY.
        if (mul_start) begin
            srca_d = rs_data;
            srcb_d = rt_data;
            sign_d = (op == MULT);
        end

        // Product capture. No HI/LO op can be accepted in BUSY, so this never
        // collides with MTHI/MTLO below.
        if (mul_done) begin
            hi_d = mult_Hi;
            lo_d = mult_Lo;
        end

        if (wd_fire) begin
            err_d = 1'b1;
        end

        if (accept) begin
            unique case (op)
                MFHI: begin
                    rd_data_d  = hi_q;
                    rd_valid_d = 1'b1;
                end
                MFLO: begin
                    rd_data_d  = lo_q;
                    rd_valid_d = 1'b1;
                end
                MTHI:    hi_d = rs_data;
                MTLO:    lo_d = rs_data;
                default: ;  // NOP, MULT/MULTU (handled above), unused
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            vin_q      <= 1'b0;
            sign_q     <= 1'b0;
            srca_q     <= '0;
            srcb_q     <= '0;
        end else begin
            wd_q       <= wd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            vin_q      <= vin_d;
            sign_q     <= sign_d;
            srca_q     <= srca_d;
            srcb_q     <= srcb_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign err          = err_q;
    assign mult_validIn = vin_q;
    assign mult_sign    = sign_q;
    assign mult_SrcA    = srca_q;
    assign mult_SrcB    = srcb_q;

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
//   Directed bench for hilo_unit with a behavioural multiplier of configurable
//   latency (0 = never completes). MFHI/MFLO expectations are queued when the
//   op is issued and checked when rd_valid pulses.
// -----------------------------------------------------------------------------
module tb_hilo_unit;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    hilo_op_t    op;
    logic [31:0] rs_data, rt_data;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err;
    logic        mult_validIn, mult_sign;
    logic [31:0] mult_SrcA, mult_SrcB;
    logic        mult_validOut;
    logic [31:0] mult_Hi, mult_Lo;

    int n_checks = 0;
    int n_fail   = 0;
    int n_push   = 0;
    int n_pop    = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    hilo_unit #(.MAX_BUSY(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op           (op),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .stall        (stall),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .err          (err),
        .mult_validIn (mult_validIn),
        .mult_sign    (mult_sign),
        .mult_SrcA    (mult_SrcA),
        .mult_SrcB    (mult_SrcB),
        .mult_validOut(mult_validOut),
        .mult_Hi      (mult_Hi),
        .mult_Lo      (mult_Lo)
    );

    // ---------------- behavioural multiplier ----------------
    int          lat  = 4;
    int          mcnt = 0;
    logic [63:0] prod;

    always @(posedge clk) begin
        if (!mult_validIn) mcnt <= 0;
        else               mcnt <= mcnt + 1;
    end

    always_comb begin
        if (mult_sign)
            prod = {{32{mult_SrcA[31]}}, mult_SrcA} * {{32{mult_SrcB[31]}}, mult_SrcB};
        else
            prod = {32'b0, mult_SrcA} * {32'b0, mult_SrcB};
    end

    assign mult_validOut = mult_validIn && (lat != 0) && (mcnt == lat - 1);
    assign mult_Hi       = prod[63:32];
    assign mult_Lo       = prod[31:0];

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rd(input logic [31:0] v);
        sb.push_back(v);
        n_push++;
    endtask

    // Scoreboard consumer: every rd_valid pulse must match the oldest entry.
    always @(negedge clk) begin
        if (rd_valid) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL rd_unexpected: observed rd_data 0x%0h expected no read", rd_data);
            end
            if (sb.size() != 0) begin
                logic [31:0] e;
                e = sb.pop_front();
                n_pop++;
                n_checks++;
                assert (rd_data === e) else begin
                    n_fail++;
                    $error("FAIL rd_data: observed 0x%0h expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    // Present an op at a negedge and hold it until accepted. Returns the number
    // of stalled cycles and the mult_validIn level seen in each of them.
    task automatic issue(input hilo_op_t o, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output logic [7:0] hist);
        stalls   = 0;
        hist     = '0;
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        #1;
        while (stall && stalls < 200) begin
            hist = {hist[6:0], mult_validIn};
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= 200) chk("issue_timeout", 64'(stalls), 64'd0);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        op       = NOP;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          st;
        logic [7:0]  h;
        int          busy;

        reset    = 1'b1;
        op_valid = 1'b0;
        op       = NOP;
        rs_data  = '0;
        rt_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_stall",     {63'b0, stall},        64'd0);
        chk("rst_rd_valid",  {63'b0, rd_valid},     64'd0);
        chk("rst_rd_data",   64'(rd_data),          64'd0);
        chk("rst_err",       {63'b0, err},          64'd0);
        chk("rst_validIn",   {63'b0, mult_validIn}, 64'd0);
        chk("rst_sign",      {63'b0, mult_sign},    64'd0);
        chk("rst_srcA",      64'(mult_SrcA),        64'd0);
        chk("rst_srcB",      64'(mult_SrcB),        64'd0);

        // MULTU 3x5, latency 4: MFHI behind it stalls 4 cycles
        lat = 4;
        issue(MULTU, 32'd3, 32'd5, st, h);
        chk("multu_stall0", 64'(st), 64'd0);
        chk("multu_vin",    {63'b0, mult_validIn}, 64'd1);
        chk("multu_sign",   {63'b0, mult_sign},    64'd0);
        chk("multu_srcA",   64'(mult_SrcA), 64'd3);
        chk("multu_srcB",   64'(mult_SrcB), 64'd5);
        push_rd(32'd0);
        issue(MFHI, 32'd0, 32'd0, st, h);
        chk("mfhi_stalls", 64'(st), 64'd4);
        push_rd(32'd15);
        issue(MFLO, 32'd0, 32'd0, st, h);
        chk("mflo_nostall", 64'(st), 64'd0);

        // Signed MULT: -2 * 3; sign held through BUSY
        issue(MULT, 32'hFFFF_FFFE, 32'd3, st, h);
        busy = 0;
        while (mult_validIn && busy < 100) begin
            chk("mult_sign_busy", {63'b0, mult_sign}, 64'd1);
            busy++;
            @(negedge clk);
        end
        chk("mult_busy_len", 64'(busy), 64'd4);
        push_rd(32'hFFFF_FFFF);
        issue(MFHI, 32'd0, 32'd0, st, h);
        push_rd(32'hFFFF_FFFA);
        issue(MFLO, 32'd0, 32'd0, st, h);

        // MFLO during BUSY returns the new Lo
        issue(MULTU, 32'd10, 32'd10, st, h);
        push_rd(32'd100);
        issue(MFLO, 32'd0, 32'd0, st, h);
        chk("mflo_busy_stalls", 64'(st), 64'd4);

        // Back-to-back MULTU: stalls through BUSY plus one DRAIN cycle
        issue(MULTU, 32'd4, 32'd4, st, h);
        issue(MULTU, 32'd2, 32'd2, st, h);
        chk("b2b_stalls", 64'(st), 64'd5);
        chk("b2b_vin_hist", 64'(h[4:0]), 64'b11110);
        chk("b2b_vin_rise", {63'b0, mult_validIn}, 64'd1);
        push_rd(32'd4);
        issue(MFLO, 32'd0, 32'd0, st, h);

        // MTHI then MFHI next cycle
        issue(MTHI, 32'hDEAD_BEEF, 32'd0, st, h);
        push_rd(32'hDEAD_BEEF);
        issue(MFHI, 32'd0, 32'd0, st, h);
        chk("mthi_mfhi_stall", 64'(st), 64'd0);

        // MTLO during BUSY is stalled and overrides the product Lo
        issue(MULTU, 32'd6, 32'd7, st, h);
        issue(MTLO, 32'h1234_5678, 32'd0, st, h);
        chk("mtlo_busy_stalls", 64'(st), 64'd4);
        push_rd(32'h1234_5678);
        issue(MFLO, 32'd0, 32'd0, st, h);
        push_rd(32'd0);
        issue(MFHI, 32'd0, 32'd0, st, h);

        // Watchdog: multiplier never completes
        lat = 0;
        issue(MULTU, 32'd9, 32'd9, st, h);
        busy = 0;
        while (mult_validIn && busy < 300) begin
            busy++;
            @(negedge clk);
        end
        chk("wd_busy_len", 64'(busy), 64'd64);
        chk("wd_err",      {63'b0, err}, 64'd1);
        push_rd(32'd0);
        issue(MFHI, 32'd0, 32'd0, st, h);
        push_rd(32'h1234_5678);
        issue(MFLO, 32'd0, 32'd0, st, h);
        lat = 2;
        issue(MULTU, 32'd3, 32'd3, st, h);
        push_rd(32'd9);
        issue(MFLO, 32'd0, 32'd0, st, h);
        chk("wd_mflo_stalls", 64'(st), 64'd2);
        chk("wd_err_sticky",  {63'b0, err}, 64'd1);
        idle(3);

        // Reset in the middle of BUSY
        lat = 10;
        issue(MULTU, 32'd5, 32'd5, st, h);
        idle(3);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_vin",      {63'b0, mult_validIn}, 64'd0);
        chk("mid_rst_sign",     {63'b0, mult_sign},    64'd0);
        chk("mid_rst_srcA",     64'(mult_SrcA),        64'd0);
        chk("mid_rst_srcB",     64'(mult_SrcB),        64'd0);
        chk("mid_rst_err",      {63'b0, err},          64'd0);
        chk("mid_rst_rd_valid", {63'b0, rd_valid},     64'd0);
        chk("mid_rst_rd_data",  64'(rd_data),          64'd0);
        reset = 1'b0;
        push_rd(32'd0);
        issue(MFLO, 32'd0, 32'd0, st, h);
        chk("mid_rst_mflo_stall", 64'(st), 64'd0);
        lat = 4;
        issue(MULTU, 32'd7, 32'd6, st, h);
        push_rd(32'd42);
        issue(MFLO, 32'd0, 32'd0, st, h);
        push_rd(32'd0);
        issue(MFHI, 32'd0, 32'd0, st, h);
        idle(4);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("sb_count",   64'(n_pop),     64'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: observed no completion expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
